amm_burst_writer: RTL

Write-side Avalon-MM master of the memory checker. Consumes one packet descriptor per handshake: word address, burst word count, first/last byte masks and data pattern. Issues it as a single Avalon-MM write burst with byteenable trimming on the edge words. Sits downstream of the packet/transaction generator and drives the memory-under-test write port.

---
 rtl/amm_burst_writer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/amm_burst_writer.sv
// Avalon-MM write-burst master: one descriptor in, one trimmed write burst out.
// Optional statistics counters are enabled by defining WR_STAT_EN.
module amm_burst_writer #(
   parameter int AMM_DATA_W  = 128,
   parameter int AMM_ADDR_W  = 12,
   parameter int AMM_BURST_W = 11,
   parameter     ADDR_TYPE   = "BYTE"
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      pkt_valid_i,
   output logic                      pkt_ready_o,
   input  logic [AMM_ADDR_W-1:0]     pkt_word_addr_i,
   input  logic [AMM_BURST_W-1:0]    pkt_burst_cnt_i,
   input  logic [AMM_DATA_W/8-1:0]   pkt_start_mask_i,
   input  logic [AMM_DATA_W/8-1:0]   pkt_end_mask_i,
   input  logic [7:0]                pkt_data_ptrn_i,
   input  logic                      pkt_data_ptrn_type_i,
   output logic [AMM_ADDR_W-1:0]     amm_address_o,
   output logic                      amm_write_o,
   output logic [AMM_DATA_W-1:0]     amm_writedata_o,
   output logic [AMM_DATA_W/8-1:0]   amm_byteenable_o,
   output logic [AMM_BURST_W-1:0]    amm_burstcount_o,
   input  logic                      amm_waitrequest_i,
   output logic                      busy_o,
   output logic [31:0]               words_written_o,
   output logic [15:0]               pkts_done_o
);

   localparam int BeW       = AMM_DATA_W / 8;
   localparam int Reps      = AMM_DATA_W / 32;
   localparam int AddrShift = $clog2(BeW);

   typedef enum logic {StIdle, StWrite} state_e;

   state_e                 state;
   logic [AMM_BURST_W-1:0] words_left;
   logic [BeW-1:0]         end_mask;
   logic                   rnd_mode;
   logic [31:0]            lfsr;
   logic [31:0]            lfsr_nxt;
   logic [31:0]            seed;
   logic [AMM_ADDR_W-1:0]  addr_map;
   logic                   beat;
   logic                   last_beat;

   // Galois form of x^32+x^22+x^2+x+1, shifting right.
   assign lfsr_nxt  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
   assign seed      = (pkt_data_ptrn_i == 8'h00) ? 32'h1 : {4{pkt_data_ptrn_i}};
   assign addr_map  = (ADDR_TYPE == "BYTE") ? (pkt_word_addr_i << AddrShift) : pkt_word_addr_i;
   assign beat      = (state == StWrite) && amm_write_o && !amm_waitrequest_i;
   assign last_beat = beat && (words_left == AMM_BURST_W'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= StIdle;
         pkt_ready_o      <= 1'b0;
         amm_address_o    <= '0;
         amm_write_o      <= 1'b0;
         amm_writedata_o  <= '0;
         amm_byteenable_o <= '0;
         amm_burstcount_o <= '0;
         busy_o           <= 1'b0;
         words_left       <= '0;
         end_mask         <= '0;
         rnd_mode         <= 1'b0;
         lfsr             <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               pkt_ready_o <= 1'b1;
               // Zero-length descriptors are consumed here and never reach the bus.
               if (pkt_valid_i && pkt_ready_o && (pkt_burst_cnt_i != '0)) begin
                  amm_address_o    <= addr_map;
                  amm_burstcount_o <= pkt_burst_cnt_i;
                  words_left       <= pkt_burst_cnt_i;
                  end_mask         <= pkt_end_mask_i;
                  rnd_mode         <= pkt_data_ptrn_type_i;
                  lfsr             <= seed;
                  amm_byteenable_o <= (pkt_burst_cnt_i == AMM_BURST_W'(1)) ?
                                      (pkt_start_mask_i & pkt_end_mask_i) : pkt_start_mask_i;
                  amm_writedata_o  <= pkt_data_ptrn_type_i ? {Reps{seed}} :
                                      {BeW{pkt_data_ptrn_i}};
                  amm_write_o      <= 1'b1;
                  pkt_ready_o      <= 1'b0;
                  busy_o           <= 1'b1;
                  state            <= StWrite;
               end
            end
            StWrite: begin
               if (last_beat) begin
                  amm_write_o <= 1'b0;
                  busy_o      <= 1'b0;
                  pkt_ready_o <= 1'b1;
                  state       <= StIdle;
               end else if (beat) begin
                  words_left       <= words_left - AMM_BURST_W'(1);
                  amm_byteenable_o <= (words_left == AMM_BURST_W'(2)) ? end_mask : '1;
                  lfsr             <= lfsr_nxt;
                  if (rnd_mode) begin
                     amm_writedata_o <= {Reps{lfsr_nxt}};
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef WR_STAT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         words_written_o <= '0;
         pkts_done_o     <= '0;
      end else begin
         if (beat && (words_written_o != '1)) begin
            words_written_o <= words_written_o + 32'd1;
         end
         if (last_beat && (pkts_done_o != '1)) begin
            pkts_done_o <= pkts_done_o + 16'd1;
         end
      end
   end
`else
   assign words_written_o = '0;
   assign pkts_done_o     = '0;
`endif

endmodule
